// File: rtl/arashi_pkg.sv
// Shared types and constants for the arashi host-side thread issuer.
// Thread FSM state encoding, host op codes and ctrl nibble layout.
package arashi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2,
    RSP     = 2'd3
  } thread_state_e;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam int CTRL_W_ENA = 0;
  localparam int CTRL_R_ENA = 1;
  localparam int CTRL_W_ID  = 2;
  localparam int CTRL_R_ID  = 3;

  // The id bit only appears in the field of the enable that is active.
  function automatic logic [3:0] make_ctrl(input logic w_ena, input logic r_ena, input logic id);
    logic [3:0] c;
    c             = '0;
    c[CTRL_W_ENA] = w_ena;
    c[CTRL_R_ENA] = r_ena;
    c[CTRL_W_ID]  = w_ena & id;
    c[CTRL_R_ID]  = r_ena & id;
    return c;
  endfunction

endpackage

// File: rtl/arashi_thread_issuer_if.sv
// Host command/response and core ctrl/data bundle for all issuer threads.
// master = host plus core side, slave = the issuer.
interface arashi_thread_issuer_if #(
    parameter int DATA_WIDTH       = 32,
    parameter int THREAD_NUM_WIDTH = 2
);
    localparam int T = 1 << THREAD_NUM_WIDTH;

    logic [T-1:0]            cmd_valid;
    logic [T-1:0]            cmd_ready;
    logic [2*T-1:0]          cmd_op;
    logic [T-1:0]            cmd_id;
    logic [DATA_WIDTH*T-1:0] cmd_wdata;
    logic [T-1:0]            rsp_valid;
    logic [T-1:0]            rsp_ready;
    logic [T-1:0]            rsp_err;
    logic [DATA_WIDTH*T-1:0] rsp_data;
    logic [4*T-1:0]          ctrl;
    logic [DATA_WIDTH*T-1:0] data_in;
    logic [T-1:0]            w_ready;
    logic [T-1:0]            r_ready;
    logic [DATA_WIDTH*T-1:0] data_out;

    modport master (
        output cmd_valid, cmd_op, cmd_id, cmd_wdata, rsp_ready, w_ready, r_ready, data_out,
        input  cmd_ready, rsp_valid, rsp_err, rsp_data, ctrl, data_in
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_id, cmd_wdata, rsp_ready, w_ready, r_ready, data_out,
        output cmd_ready, rsp_valid, rsp_err, rsp_data, ctrl, data_in
    );
endinterface

// File: rtl/arashi_thread_fsm.sv
// One issuer thread: request FSM, wait watchdog and registered core/response outputs.
// Outputs are registered from the next state, so they track the state one cycle after accept.
module arashi_thread_fsm
    import arashi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic                  cmd_id,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [3:0]            ctrl,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic                  w_ready,
    input  logic                  r_ready,
    input  logic [DATA_WIDTH-1:0] data_out
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    thread_state_e           state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic                    id_q, id_n;
    logic [DATA_WIDTH-1:0]   wdata_n, rsp_data_n;
    logic                    rsp_err_n;
    logic                    expired;

    assign cmd_ready = (state == IDLE);
    assign expired   = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        id_n       = id_q;
        wdata_n    = data_in;
        rsp_err_n  = rsp_err;
        rsp_data_n = rsp_data;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WR: begin
                            state_n = WR_WAIT;
                            id_n    = cmd_id;
                            wdata_n = cmd_wdata;
                        end
                        OP_RD: begin
                            state_n = RD_WAIT;
                            id_n    = cmd_id;
                        end
                        OP_ILL: begin
                            state_n    = RSP;
                            rsp_err_n  = 1'b1;
                            rsp_data_n = '0;
                        end
                        OP_NOP:  ;
                        default: ;
                    endcase
                end
            end
            // The strobe is tested before the watchdog so a same-cycle strobe wins.
            WR_WAIT: begin
                if (w_ready) begin
                    state_n = IDLE;
                end else if (expired) begin
                    state_n    = RSP;
                    rsp_err_n  = 1'b1;
                    rsp_data_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RD_WAIT: begin
                if (r_ready) begin
                    state_n    = RSP;
                    rsp_err_n  = 1'b0;
                    rsp_data_n = data_out;
                end else if (expired) begin
                    state_n    = RSP;
                    rsp_err_n  = 1'b1;
                    rsp_data_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            id_q      <= 1'b0;
            ctrl      <= '0;
            data_in   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            id_q      <= id_n;
            ctrl      <= make_ctrl(state_n == WR_WAIT, state_n == RD_WAIT, id_n);
            data_in   <= (state_n == WR_WAIT) ? wdata_n : '0;
            rsp_valid <= (state_n == RSP);
            rsp_err   <= (state_n == RSP) ? rsp_err_n : 1'b0;
            rsp_data  <= (state_n == RSP) ? rsp_data_n : '0;
        end
    end
endmodule

// File: rtl/arashi_thread_issuer.sv
// Host-side issuer for arashi_top: one independent arashi_thread_fsm per thread.
// The core arbitrates between threads, so this level only slices the buses.
module arashi_thread_issuer
    import arashi_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int THREAD_NUM_WIDTH = 2,
    parameter int TIMEOUT          = 255
) (
    input logic                   clk,
    input logic                   rstn,
    arashi_thread_issuer_if.slave bus
);
    localparam int T = 1 << THREAD_NUM_WIDTH;

    if (THREAD_NUM_WIDTH < 2 || THREAD_NUM_WIDTH > 4) begin : g_bad_param
        $error("arashi_thread_issuer: THREAD_NUM_WIDTH must be in 2..4");
    end

    for (genvar i = 0; i < T; i++) begin : g_thread
        arashi_thread_fsm #(
            .DATA_WIDTH (DATA_WIDTH),
            .TIMEOUT    (TIMEOUT)
        ) u_fsm (
            .clk       (clk),
            .rstn      (rstn),
            .cmd_valid (bus.cmd_valid[i]),
            .cmd_ready (bus.cmd_ready[i]),
            .cmd_op    (bus.cmd_op[2*i +: 2]),
            .cmd_id    (bus.cmd_id[i]),
            .cmd_wdata (bus.cmd_wdata[DATA_WIDTH*i +: DATA_WIDTH]),
            .rsp_valid (bus.rsp_valid[i]),
            .rsp_ready (bus.rsp_ready[i]),
            .rsp_err   (bus.rsp_err[i]),
            .rsp_data  (bus.rsp_data[DATA_WIDTH*i +: DATA_WIDTH]),
            .ctrl      (bus.ctrl[4*i +: 4]),
            .data_in   (bus.data_in[DATA_WIDTH*i +: DATA_WIDTH]),
            .w_ready   (bus.w_ready[i]),
            .r_ready   (bus.r_ready[i]),
            .data_out  (bus.data_out[DATA_WIDTH*i +: DATA_WIDTH])
        );
    end
endmodule

// File: tb/tb_arashi_thread_issuer.sv
// Directed bench for arashi_thread_issuer: 4 threads, 32-bit data, TIMEOUT=8.
// Expected responses are queued when stimulus is driven and popped when the DUT responds.
module tb_arashi_thread_issuer;
    localparam int DW  = 32;
    localparam int TNW = 2;
    localparam int TO  = 8;

    typedef struct {
        int          thread;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic clk;
    logic rstn;
    int   errors;
    int   checks;
    rsp_t sb[$];

    arashi_thread_issuer_if #(.DATA_WIDTH(DW), .THREAD_NUM_WIDTH(TNW)) bus ();

    arashi_thread_issuer #(
        .DATA_WIDTH       (DW),
        .THREAD_NUM_WIDTH (TNW),
        .TIMEOUT          (TO)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_strobes();
        bus.cmd_valid = '0;
        bus.w_ready   = '0;
        bus.r_ready   = '0;
    endtask

    task automatic check_rsp();
        rsp_t e;
        int   n;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        n = 0;
        while (bus.rsp_valid[e.thread] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk($sformatf("rsp_valid[%0d]", e.thread), 64'(bus.rsp_valid[e.thread]), 64'd1);
        chk($sformatf("rsp_err[%0d]", e.thread), 64'(bus.rsp_err[e.thread]), 64'(e.err));
        chk($sformatf("rsp_data[%0d]", e.thread), 64'(bus.rsp_data[32*e.thread +: 32]), 64'(e.data));
    endtask

    initial begin
        logic [3:0] seen;
        errors = 0;
        checks = 0;
        clr_strobes();
        bus.cmd_op    = '0;
        bus.cmd_id    = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = '0;
        bus.data_out  = '0;
        rstn = 1'b0;
        step();
        step();
        chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'hF);
        chk("reset_ctrl", 64'(bus.ctrl), 64'h0);
        chk("reset_data_in", 64'(bus.data_in[63:0] | bus.data_in[127:64]), 64'h0);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("reset_rsp_err", 64'(bus.rsp_err), 64'h0);
        chk("reset_rsp_data", 64'(bus.rsp_data[63:0] | bus.rsp_data[127:64]), 64'h0);
        rstn = 1'b1;
        step();
        chk("post_reset_cmd_ready", 64'(bus.cmd_ready), 64'hF);

        // 1: write T0, w_ready on cycle 4
        bus.cmd_valid       = 4'b0001;
        bus.cmd_op          = 8'b00_00_00_01;
        bus.cmd_id          = 4'b0001;
        bus.cmd_wdata[31:0] = 32'hDEADBEEF;
        step();
        clr_strobes();
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("t1_ctrl_c%0d", c), 64'(bus.ctrl[3:0]), 64'b0101);
            chk($sformatf("t1_data_in_c%0d", c), 64'(bus.data_in[31:0]), 64'hDEADBEEF);
            chk($sformatf("t1_cmd_ready_c%0d", c), 64'(bus.cmd_ready[0]), 64'd0);
            if (c == 4) bus.w_ready = 4'b0001;
            step();
        end
        bus.w_ready = '0;
        chk("t1_ctrl_c5", 64'(bus.ctrl[3:0]), 64'b0000);
        chk("t1_data_in_c5", 64'(bus.data_in[31:0]), 64'h0);
        chk("t1_cmd_ready_c5", 64'(bus.cmd_ready[0]), 64'd1);
        chk("t1_no_rsp", 64'(bus.rsp_valid), 64'h0);

        // 2: read T2, response held while rsp_ready is low
        bus.cmd_valid = 4'b0100;
        bus.cmd_op    = 8'b00_10_00_00;
        bus.cmd_id    = 4'b0000;
        step();
        clr_strobes();
        chk("t2_ctrl_rd", 64'(bus.ctrl), 64'h0200);
        bus.r_ready  = 4'b0100;
        bus.data_out = {32'hAAAA0003, 32'h12345678, 32'hAAAA0001, 32'hAAAA0000};
        sb.push_back('{2, 1'b0, 32'h12345678});
        step();
        bus.r_ready  = '0;
        bus.data_out = {32'hBBBB0003, 32'hBBBB0002, 32'hBBBB0001, 32'hBBBB0000};
        chk("t2_ctrl_after", 64'(bus.ctrl), 64'h0);
        check_rsp();
        step();
        chk("t2_hold1_valid", 64'(bus.rsp_valid), 64'b0100);
        chk("t2_hold1_data", 64'(bus.rsp_data[95:64]), 64'h12345678);
        step();
        chk("t2_hold2_valid", 64'(bus.rsp_valid), 64'b0100);
        chk("t2_hold2_data", 64'(bus.rsp_data[95:64]), 64'h12345678);
        chk("t2_hold2_err", 64'(bus.rsp_err), 64'h0);
        bus.rsp_ready = 4'b0100;
        step();
        bus.rsp_ready = '0;
        chk("t2_cleared_valid", 64'(bus.rsp_valid), 64'h0);
        chk("t2_cleared_data", 64'(bus.rsp_data[95:64]), 64'h0);
        chk("t2_cmd_ready", 64'(bus.cmd_ready), 64'hF);

        // 3: read T1 with no strobe -> timeout after exactly 8 enable cycles
        bus.cmd_valid = 4'b0010;
        bus.cmd_op    = 8'b00_00_10_00;
        bus.cmd_id    = 4'b0010;
        sb.push_back('{1, 1'b1, 32'h0});
        step();
        clr_strobes();
        for (int c = 1; c <= TO; c++) begin
            chk($sformatf("t3_r_ena_c%0d", c), 64'(bus.ctrl[7:4]), 64'b1010);
            chk($sformatf("t3_no_rsp_c%0d", c), 64'(bus.rsp_valid[1]), 64'd0);
            step();
        end
        chk("t3_ctrl_off", 64'(bus.ctrl[7:4]), 64'b0000);
        check_rsp();
        bus.r_ready  = 4'b0010;
        bus.data_out = {32'hCCCC0003, 32'hCCCC0002, 32'hCAFEF00D, 32'hCCCC0000};
        step();
        chk("t3_late_valid", 64'(bus.rsp_valid[1]), 64'd1);
        chk("t3_late_err", 64'(bus.rsp_err[1]), 64'd1);
        chk("t3_late_data", 64'(bus.rsp_data[63:32]), 64'h0);
        bus.rsp_ready = 4'b0010;
        step();
        bus.r_ready   = '0;
        bus.rsp_ready = '0;
        chk("t3_done_valid", 64'(bus.rsp_valid), 64'h0);
        chk("t3_done_ctrl", 64'(bus.ctrl), 64'h0);
        chk("t3_done_cmd_ready", 64'(bus.cmd_ready[1]), 64'd1);

        // 4: all threads at once, strobes in order 3,0,1,2
        bus.cmd_valid = 4'hF;
        bus.cmd_op    = 8'b10_01_10_01;
        bus.cmd_id    = 4'b0110;
        bus.cmd_wdata = {32'h77777777, 32'h22222222, 32'h66666666, 32'hA0A0A0A0};
        bus.data_out  = {32'hD0D0D0D3, 32'hD0D0D0D2, 32'hD0D0D0D1, 32'hD0D0D0D0};
        step();
        clr_strobes();
        chk("t4_ctrl_c1", 64'(bus.ctrl), 64'h25A1);
        chk("t4_data_in_lo", 64'(bus.data_in[63:0]), {32'h0, 32'hA0A0A0A0});
        chk("t4_data_in_hi", 64'(bus.data_in[127:64]), {32'h0, 32'h22222222});
        bus.r_ready  = 4'b1000;
        bus.data_out = {32'h33333333, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF};
        sb.push_back('{3, 1'b0, 32'h33333333});
        step();
        bus.r_ready = '0;
        chk("t4_ctrl_c2", 64'(bus.ctrl), 64'h05A1);
        chk("t4_rsp_valid_c2", 64'(bus.rsp_valid), 64'b1000);
        bus.w_ready = 4'b0001;
        step();
        bus.w_ready = '0;
        chk("t4_ctrl_c3", 64'(bus.ctrl), 64'h05A0);
        chk("t4_data_in_c3", 64'(bus.data_in[63:0] | bus.data_in[127:96]), 64'h0);
        chk("t4_cmd_ready_c3", 64'(bus.cmd_ready), 64'b0001);
        bus.r_ready  = 4'b0010;
        bus.data_out = {32'h99999999, 32'h44444444, 32'h11111111, 32'h88888888};
        sb.push_back('{1, 1'b0, 32'h11111111});
        step();
        bus.r_ready = '0;
        chk("t4_ctrl_c4", 64'(bus.ctrl), 64'h0500);
        chk("t4_rsp_valid_c4", 64'(bus.rsp_valid), 64'b1010);
        bus.w_ready = 4'b0100;
        step();
        bus.w_ready = '0;
        chk("t4_ctrl_c5", 64'(bus.ctrl), 64'h0);
        chk("t4_data_in_c5", 64'(bus.data_in[63:0] | bus.data_in[127:64]), 64'h0);
        chk("t4_cmd_ready_c5", 64'(bus.cmd_ready), 64'b0101);
        check_rsp();
        check_rsp();
        chk("t4_rsp_err", 64'(bus.rsp_err), 64'h0);
        bus.rsp_ready = 4'hF;
        step();
        bus.rsp_ready = '0;
        chk("t4_rsp_cleared", 64'(bus.rsp_valid), 64'h0);
        chk("t4_cmd_ready_end", 64'(bus.cmd_ready), 64'hF);

        // 5: illegal op on T3, nop on T1
        bus.cmd_valid = 4'b1010;
        bus.cmd_op    = 8'b11_00_00_00;
        bus.cmd_id    = 4'b1010;
        sb.push_back('{3, 1'b1, 32'h0});
        step();
        clr_strobes();
        chk("t5_ctrl", 64'(bus.ctrl), 64'h0);
        chk("t5_cmd_ready", 64'(bus.cmd_ready), 64'b0111);
        chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'b1000);
        check_rsp();
        bus.rsp_ready = 4'b1000;
        step();
        bus.rsp_ready = '0;
        chk("t5_cleared", 64'(bus.rsp_valid), 64'h0);

        // 6: reset while T0 waits on a read and T1 holds a response
        bus.cmd_valid = 4'b0011;
        bus.cmd_op    = 8'b00_00_10_10;
        bus.cmd_id    = 4'b0001;
        step();
        clr_strobes();
        bus.r_ready  = 4'b0010;
        bus.data_out = {32'h0, 32'h0, 32'h55555555, 32'h0};
        step();
        bus.r_ready = '0;
        chk("t6_pre_rsp", 64'(bus.rsp_valid), 64'b0010);
        chk("t6_pre_ctrl", 64'(bus.ctrl), 64'h000A);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("t6_rst_ctrl", 64'(bus.ctrl), 64'h0);
        chk("t6_rst_data_in", 64'(bus.data_in[63:0] | bus.data_in[127:64]), 64'h0);
        chk("t6_rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("t6_rst_rsp_err", 64'(bus.rsp_err), 64'h0);
        chk("t6_rst_rsp_data", 64'(bus.rsp_data[63:0] | bus.rsp_data[127:64]), 64'h0);
        chk("t6_rst_cmd_ready", 64'(bus.cmd_ready), 64'hF);
        seen = '0;
        for (int c = 0; c < 12; c++) begin
            step();
            seen = seen | bus.rsp_valid;
        end
        chk("t6_no_lost_rsp", 64'(seen), 64'h0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
